// File: rtl/ray_dispatcher.sv
// Frame scheduler for a quad ray unit: walks the frame in raster order, derives each
// pixel's ray direction incrementally from the camera vectors and issues it over start/ready.

module ray_dispatcher_lane #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         step_col,
  input  logic         step_row,
  input  logic [W-1:0] v0,
  input  logic [W-1:0] dx,
  input  logic [W-1:0] dy,
  output logic [W-1:0] cur
);
  logic [W-1:0] row, dx_r, dy_r;

  // The row-start direction is kept separately so a row wrap never inherits
  // the accumulated per-column sum.
  always_ff @(posedge clock) begin
    if (reset) begin
      row  <= '0;
      cur  <= '0;
      dx_r <= '0;
      dy_r <= '0;
    end else if (load) begin
      row  <= v0;
      cur  <= v0;
      dx_r <= dx;
      dy_r <= dy;
    end else if (step_row) begin
      row <= row + dy_r;
      cur <= row + dy_r;
    end else if (step_col) begin
      cur <= cur + dx_r;
    end
  end
endmodule

module ray_dispatcher #(
  parameter int POSITION_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DIM_WIDTH      = 10,
  parameter int PIXEL_STRIDE   = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frameStart,
  input  logic [DIM_WIDTH-1:0]        frameWidth,
  input  logic [DIM_WIDTH-1:0]        frameHeight,
  input  logic [ADDRESS_WIDTH-1:0]    frameBase,
  input  logic [3*POSITION_WIDTH-1:0] cameraQ,
  input  logic [3*POSITION_WIDTH-1:0] cameraV0,
  input  logic [3*POSITION_WIDTH-1:0] cameraDx,
  input  logic [3*POSITION_WIDTH-1:0] cameraDy,
  output logic                        frameBusy,
  output logic                        frameDone,
  output logic                        flush,
  output logic                        unitStart,
  input  logic                        unitReady,
  input  logic                        unitBusy,
  output logic [3*POSITION_WIDTH-1:0] rayQ,
  output logic [3*POSITION_WIDTH-1:0] rayV,
  output logic [ADDRESS_WIDTH-1:0]    pixelAddress
);
  typedef enum logic [1:0] {IDLE, FLUSH, ISSUE, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [DIM_WIDTH-1:0]   width, height, x, y;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic                   drain_first;
  logic                   load, step_col, step_row, finish;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step_col  = 1'b0;
    step_row  = 1'b0;
    finish    = 1'b0;
    frameBusy = (state != IDLE);
    flush     = (state == FLUSH);
    unitStart = (state == ISSUE) && unitReady;
    case (state)
      IDLE: begin
        if (frameStart) begin
          load      = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (width == '0 || height == '0) state_nxt = DRAIN;
        else                             state_nxt = ISSUE;
      end
      ISSUE: begin
        if (unitStart) begin
          if (x < width - DIM_WIDTH'(1))       step_col  = 1'b1;
          else if (y < height - DIM_WIDTH'(1)) step_row  = 1'b1;
          else                                 state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // unitBusy lags the final start by a cycle, so the entry cycle can't trust it
        if (!drain_first && !unitBusy) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      width       <= '0;
      height      <= '0;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      rayQ        <= '0;
      drain_first <= 1'b0;
      frameDone   <= 1'b0;
    end else begin
      frameDone   <= finish;
      drain_first <= (state != DRAIN);
      if (load) begin
        width  <= frameWidth;
        height <= frameHeight;
        x      <= '0;
        y      <= '0;
        addr   <= frameBase;
        rayQ   <= cameraQ;
      end else if (step_row) begin
        x    <= '0;
        y    <= y + DIM_WIDTH'(1);
        addr <= addr + ADDRESS_WIDTH'(PIXEL_STRIDE);
      end else if (step_col) begin
        x    <= x + DIM_WIDTH'(1);
        addr <= addr + ADDRESS_WIDTH'(PIXEL_STRIDE);
      end
    end
  end

  assign pixelAddress = addr;

  for (genvar i = 0; i < 3; i++) begin : g_lane
    ray_dispatcher_lane #(.W(POSITION_WIDTH)) u_lane (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .step_col (step_col),
      .step_row (step_row),
      .v0       (cameraV0[i*POSITION_WIDTH +: POSITION_WIDTH]),
      .dx       (cameraDx[i*POSITION_WIDTH +: POSITION_WIDTH]),
      .dy       (cameraDy[i*POSITION_WIDTH +: POSITION_WIDTH]),
      .cur      (rayV[i*POSITION_WIDTH +: POSITION_WIDTH])
    );
  end
endmodule

// File: tb/tb_ray_dispatcher.sv
// Scoreboard bench for ray_dispatcher: expected rays come from a closed-form pixel model
// (V0 + x*Dx + y*Dy), a negedge monitor pops and compares on every issued ray.

module tb_ray_dispatcher;
  logic        clock, reset, frameStart;
  logic [9:0]  frameWidth, frameHeight;
  logic [31:0] frameBase;
  logic [47:0] cameraQ, cameraV0, cameraDx, cameraDy;
  logic        frameBusy, frameDone, flush, unitStart, unitReady, unitBusy;
  logic [47:0] rayQ, rayV;
  logic [31:0] pixelAddress;

  ray_dispatcher dut (
    .clock(clock), .reset(reset), .frameStart(frameStart),
    .frameWidth(frameWidth), .frameHeight(frameHeight), .frameBase(frameBase),
    .cameraQ(cameraQ), .cameraV0(cameraV0), .cameraDx(cameraDx), .cameraDy(cameraDy),
    .frameBusy(frameBusy), .frameDone(frameDone), .flush(flush), .unitStart(unitStart),
    .unitReady(unitReady), .unitBusy(unitBusy), .rayQ(rayQ), .rayV(rayV),
    .pixelAddress(pixelAddress)
  );

  typedef struct {
    logic [47:0] v;
    logic [31:0] a;
  } ray_t;

  ray_t        expq[$];
  logic [47:0] exp_q;
  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int flush_cnt = 0, flush_cyc = -1, done_cnt = 0, done_cyc = -1;
  int start_cnt = 0, first_start = -1, last_start = -1000;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [47:0] mk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [47:0] ray_dir(input logic [47:0] v0, input logic [47:0] dx,
                                          input logic [47:0] dy, input int px, input int py);
    logic [47:0] r;
    longint s;
    for (int i = 0; i < 3; i++) begin
      s = longint'(v0[i*16 +: 16]) + longint'(px) * longint'(dx[i*16 +: 16])
        + longint'(py) * longint'(dy[i*16 +: 16]);
      r[i*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  // Monitor: every start must match the head of the queue; while a ray is pending
  // and not taken, the outputs must keep presenting that same ray.
  always @(negedge clock) begin
    if (!reset) begin
      if (flush) begin
        flush_cnt++;
        flush_cyc = cyc;
      end
      if (frameDone) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_at_done", {63'd0, frameBusy}, 64'd0);
      end
      if (unitStart) begin
        start_cnt++;
        last_start = cyc;
        if (first_start < 0) first_start = cyc;
        if (expq.size() == 0) begin
          check("extra_start", 64'd1, 64'd0);
        end else begin
          ray_t r;
          r = expq.pop_front();
          check("rayV", {16'd0, rayV}, {16'd0, r.v});
          check("pixelAddress", {32'd0, pixelAddress}, {32'd0, r.a});
          check("rayQ", {16'd0, rayQ}, {16'd0, exp_q});
        end
      end else if (frameBusy && !flush && expq.size() > 0) begin
        check("hold_rayV", {16'd0, rayV}, {16'd0, expq[0].v});
        check("hold_addr", {32'd0, pixelAddress}, {32'd0, expq[0].a});
      end
    end
  end

  // rmode: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random.
  // hold: unitBusy stays high until this many cycles after the latest start.
  task automatic run_frame(input int w, input int h, input logic [31:0] base,
                           input logic [47:0] q, input logic [47:0] v0,
                           input logic [47:0] dx, input logic [47:0] dy,
                           input int rmode, input int hold, input int abort_after,
                           input bit midstart);
    int t, total, b_flush, b_done, b_start, timeout, exp_done;
    ray_t r;
    total = w * h;
    expq.delete();
    for (int py = 0; py < h; py++)
      for (int px = 0; px < w; px++) begin
        r.v = ray_dir(v0, dx, dy, px, py);
        r.a = base + 32'(py * w + px);
        expq.push_back(r);
      end
    exp_q = q;
    b_flush = flush_cnt; b_done = done_cnt; b_start = start_cnt;
    first_start = -1; last_start = -1000;

    @(posedge clock); #1;
    frameWidth = 10'(w); frameHeight = 10'(h); frameBase = base;
    cameraQ = q; cameraV0 = v0; cameraDx = dx; cameraDy = dy;
    frameStart = 1'b1; unitReady = 1'b0; unitBusy = 1'b0;
    t = cyc;
    timeout = 0;
    while (done_cnt == b_done && timeout < 3000) begin
      @(posedge clock); #1;
      timeout++;
      frameStart = 1'b0;
      // scramble config so any failure to latch shows up as a miscompare
      frameWidth = 10'($urandom_range(1, 9)); frameHeight = 10'($urandom_range(1, 9));
      frameBase = $urandom; cameraQ = {16'($urandom), 32'($urandom)};
      cameraV0 = {16'($urandom), 32'($urandom)}; cameraDx = {16'($urandom), 32'($urandom)};
      cameraDy = {16'($urandom), 32'($urandom)};
      case (rmode)
        0:       unitReady = 1'b1;
        1:       unitReady = ((cyc - t - 2) % 3 == 0);
        default: unitReady = ($urandom_range(0, 3) != 0);
      endcase
      unitBusy = ((cyc - last_start) < hold);
      if (midstart && (start_cnt - b_start == 2)) frameStart = 1'b1;
      if (abort_after > 0 && (start_cnt - b_start == abort_after)) begin
        reset = 1'b1;
        unitReady = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst_frameBusy", {63'd0, frameBusy}, 64'd0);
        check("rst_frameDone", {63'd0, frameDone}, 64'd0);
        check("rst_flush", {63'd0, flush}, 64'd0);
        check("rst_unitStart", {63'd0, unitStart}, 64'd0);
        check("rst_rayQ", {16'd0, rayQ}, 64'd0);
        check("rst_rayV", {16'd0, rayV}, 64'd0);
        check("rst_addr", {32'd0, pixelAddress}, 64'd0);
        reset = 1'b0;
        unitReady = 1'b0;
        expq.delete();
        repeat (6) @(posedge clock);
        #1;
        check("abort_no_done", 64'(done_cnt - b_done), 64'd0);
        check("abort_no_flush", 64'(flush_cnt - b_flush), 64'd1);
        check("abort_idle", {63'd0, frameBusy}, 64'd0);
        return;
      end
    end
    unitReady = 1'b0;
    unitBusy  = 1'b0;
    check("done_timeout", 64'(timeout >= 3000), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    check("done_count", 64'(done_cnt - b_done), 64'd1);
    check("flush_count", 64'(flush_cnt - b_flush), 64'd1);
    check("flush_cycle", 64'(flush_cyc - t), 64'd1);
    check("start_count", 64'(start_cnt - b_start), 64'(total));
    check("queue_drained", 64'(expq.size()), 64'd0);
    if (total > 0 && rmode == 0) begin
      check("first_start", 64'(first_start - t), 64'd2);
      check("last_start", 64'(last_start - t), 64'(1 + total));
    end
    exp_done = (total > 0) ? last_start + 1 + ((hold > 2) ? hold : 2) : t + 4;
    check("done_cycle", 64'(done_cyc), 64'(exp_done));
  endtask

  initial begin
    reset = 1'b1; frameStart = 1'b0; frameWidth = '0; frameHeight = '0; frameBase = '0;
    cameraQ = '0; cameraV0 = '0; cameraDx = '0; cameraDy = '0;
    unitReady = 1'b1; unitBusy = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_frameBusy", {63'd0, frameBusy}, 64'd0);
    check("reset_frameDone", {63'd0, frameDone}, 64'd0);
    check("reset_flush", {63'd0, flush}, 64'd0);
    check("reset_unitStart", {63'd0, unitStart}, 64'd0);
    check("reset_rayV", {16'd0, rayV}, 64'd0);
    check("reset_rayQ", {16'd0, rayQ}, 64'd0);
    check("reset_addr", {32'd0, pixelAddress}, 64'd0);
    reset = 1'b0; unitReady = 1'b0;

    run_frame(4, 2, 32'h1000, mk(5, 6, 7), mk(0, 0, 100), mk(1, 0, 0), mk(0, 1, 0), 0, 0, 0, 0);
    run_frame(4, 2, 32'h1000, mk(5, 6, 7), mk(0, 0, 100), mk(1, 0, 0), mk(0, 1, 0), 1, 0, 0, 0);
    run_frame(3, 1, 32'h2000, mk(1, 2, 3), mk(0, 0, 0), mk(16'h7FFF, 0, 0), mk(0, 0, 0), 0, 0, 0, 0);
    run_frame(0, 2, 32'h3000, mk(1, 1, 1), mk(9, 9, 9), mk(1, 1, 1), mk(2, 2, 2), 0, 0, 0, 0);
    run_frame(3, 0, 32'h3100, mk(1, 1, 1), mk(9, 9, 9), mk(1, 1, 1), mk(2, 2, 2), 1, 0, 0, 0);
    run_frame(4, 2, 32'h1000, mk(5, 6, 7), mk(0, 0, 100), mk(1, 0, 0), mk(0, 1, 0), 0, 20, 0, 1);
    run_frame(4, 2, 32'h1000, mk(5, 6, 7), mk(0, 0, 100), mk(1, 0, 0), mk(0, 1, 0), 0, 0, 3, 0);
    run_frame(4, 2, 32'h1000, mk(5, 6, 7), mk(0, 0, 100), mk(1, 0, 0), mk(0, 1, 0), 0, 0, 0, 0);
    run_frame(1, 1, 32'hFFFF_FFFF, mk(3, 3, 3), mk(1, 2, 3), mk(4, 5, 6), mk(7, 8, 9), 0, 1, 0, 0);
    for (int k = 0; k < 8; k++)
      run_frame($urandom_range(1, 6), $urandom_range(1, 4), $urandom,
                {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)},
                {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)},
                2, $urandom_range(0, 5), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
